tlb_op_ctrl: RTL and testbench

Sequencer for the TLB's maintenance instructions (TLBSRCH, TLBRD, TLBWR, TLBFILL, INVTLB). It sits between the EXE/CSR stage and the `tlb` array. It owns the array's write port, read port and invalidate strobe, and borrows search port 1 from the load/store path. Each operation is accepted by handshake, sequenced through a small FSM, and completed with a one-cycle response carrying results back for CSR update.

---
 rtl/tlb_op_ctrl.sv | 252 +++++++++++++++++++++++++
 tb/tb_tlb_op_ctrl.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: sequences TLB maintenance ops (SRCH/RD/WR/FILL/INV)
// against the TLB array, borrowing search port 1 from load/store.
module tlb_op_ctrl #(
  parameter int TLBNUM = 16,
  parameter int IDXW   = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [4:0]      req_inv_op,
  input  logic [9:0]      req_inv_asid,
  input  logic [18:0]     req_inv_vppn,
  input  logic [IDXW-1:0] csr_idx_index,
  input  logic [5:0]      csr_idx_ps,
  input  logic            csr_idx_ne,
  input  logic [18:0]     csr_ehi_vppn,
  input  logic [9:0]      csr_asid,
  input  logic [31:0]     csr_elo0,
  input  logic [31:0]     csr_elo1,
  input  logic            csr_tlbr_active,
  input  logic [18:0]     mem_s1_vppn,
  input  logic            mem_s1_va_bit12,
  input  logic [9:0]      mem_s1_asid,
  input  logic            mem_st,
  output logic            mem_stall,
  output logic [18:0]     tlb_s1_vppn,
  output logic            tlb_s1_va_bit12,
  output logic [9:0]      tlb_s1_asid,
  output logic            tlb_st_inst,
  input  logic            tlb_s1_found,
  input  logic [IDXW-1:0] tlb_s1_index,
  output logic            tlb_invtlb_valid,
  output logic [4:0]      tlb_invtlb_op,
  output logic            tlb_we,
  output logic [IDXW-1:0] tlb_w_index,
  output logic            tlb_w_e,
  output logic [18:0]     tlb_w_vppn,
  output logic [5:0]      tlb_w_ps,
  output logic [9:0]      tlb_w_asid,
  output logic            tlb_w_g,
  output logic [19:0]     tlb_w_ppn0,
  output logic [1:0]      tlb_w_plv0,
  output logic [1:0]      tlb_w_mat0,
  output logic            tlb_w_d0,
  output logic            tlb_w_v0,
  output logic [19:0]     tlb_w_ppn1,
  output logic [1:0]      tlb_w_plv1,
  output logic [1:0]      tlb_w_mat1,
  output logic            tlb_w_d1,
  output logic            tlb_w_v1,
  output logic [IDXW-1:0] tlb_r_index,
  input  logic            tlb_r_e,
  input  logic [18:0]     tlb_r_vppn,
  input  logic [5:0]      tlb_r_ps,
  input  logic [9:0]      tlb_r_asid,
  input  logic            tlb_r_g,
  input  logic [19:0]     tlb_r_ppn0,
  input  logic [1:0]      tlb_r_plv0,
  input  logic [1:0]      tlb_r_mat0,
  input  logic            tlb_r_d0,
  input  logic            tlb_r_v0,
  input  logic [19:0]     tlb_r_ppn1,
  input  logic [1:0]      tlb_r_plv1,
  input  logic [1:0]      tlb_r_mat1,
  input  logic            tlb_r_d1,
  input  logic            tlb_r_v1,
  output logic            resp_valid,
  output logic            resp_err,
  output logic            resp_found,
  output logic [IDXW-1:0] resp_index,
  output logic            resp_rd_e,
  output logic [18:0]     resp_rd_vppn,
  output logic [5:0]      resp_rd_ps,
  output logic [9:0]      resp_rd_asid,
  output logic            resp_rd_g,
  output logic [19:0]     resp_rd_ppn0,
  output logic [1:0]      resp_rd_plv0,
  output logic [1:0]      resp_rd_mat0,
  output logic            resp_rd_d0,
  output logic            resp_rd_v0,
  output logic [19:0]     resp_rd_ppn1,
  output logic [1:0]      resp_rd_plv1,
  output logic [1:0]      resp_rd_mat1,
  output logic            resp_rd_d1,
  output logic            resp_rd_v1
);

  typedef enum logic [2:0] {
    S_IDLE, S_SRCH, S_RD, S_WR, S_INV, S_RESP
  } state_t;

  localparam int RDW = 89;

  state_t          r_state;
  logic [IDXW-1:0] r_cnt;
  logic [IDXW-1:0] r_idx;
  logic [IDXW-1:0] r_resp_index;
  logic [4:0]      r_inv_op;
  logic [9:0]      r_inv_asid;
  logic [18:0]     r_inv_vppn;
  logic            r_inv_bad;
  logic            r_resp_valid;
  logic            r_resp_err;
  logic            r_resp_found;
  logic [RDW-1:0]  r_rd;

  logic            w_srch;
  logic            w_inv;
  logic [RDW-1:0]  w_rd;
  logic [IDXW-1:0] w_cnt_nxt;
  logic            w_unused;

  assign w_srch = (r_state == S_SRCH);
  assign w_inv  = (r_state == S_INV);
  assign w_cnt_nxt = (r_cnt == IDXW'(TLBNUM - 1)) ?
                     '0 : r_cnt + IDXW'(1);

  assign w_rd = {tlb_r_e, tlb_r_vppn, tlb_r_ps,
                 tlb_r_asid, tlb_r_g,
                 tlb_r_ppn0, tlb_r_plv0, tlb_r_mat0,
                 tlb_r_d0, tlb_r_v0,
                 tlb_r_ppn1, tlb_r_plv1, tlb_r_mat1,
                 tlb_r_d1, tlb_r_v1};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_inv_op     <= '0;
      r_inv_asid   <= '0;
      r_inv_vppn   <= '0;
      r_inv_bad    <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_found <= 1'b0;
      r_resp_index <= '0;
      r_rd         <= '0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      unique case (r_state)
        S_IDLE: if (req_valid) begin
          r_idx <= (req_op == 3'd3) ? r_cnt : csr_idx_index;
          r_inv_op     <= req_inv_op;
          r_inv_asid   <= req_inv_asid;
          r_inv_vppn   <= req_inv_vppn;
          r_inv_bad    <= (req_inv_op > 5'd6);
          r_resp_found <= 1'b0;
          r_resp_index <= '0;
          unique case (1'b1)
            req_op == 3'd0: r_state <= S_SRCH;
            req_op == 3'd1: r_state <= S_RD;
            req_op == 3'd2,
            req_op == 3'd3: r_state <= S_WR;
            req_op == 3'd4: r_state <= S_INV;
            default: begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
            end
          endcase
        end
        S_SRCH: begin
          r_resp_found <= tlb_s1_found;
          r_resp_index <= tlb_s1_index;
          r_resp_valid <= 1'b1;
          r_state      <= S_RESP;
        end
        S_RD: begin
          r_rd         <= w_rd;
          r_resp_valid <= 1'b1;
          r_state      <= S_RESP;
        end
        S_WR: begin
          r_resp_valid <= 1'b1;
          r_state      <= S_RESP;
        end
        S_INV: begin
          r_resp_valid <= 1'b1;
          r_resp_err   <= r_inv_bad;
          r_state      <= S_RESP;
        end
        S_RESP: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign mem_stall = w_srch | w_inv;

  // search port is borrowed only while SRCH/INV compare
  always_comb begin
    tlb_s1_vppn     = mem_s1_vppn;
    tlb_s1_va_bit12 = mem_s1_va_bit12;
    tlb_s1_asid     = mem_s1_asid;
    tlb_st_inst     = mem_st;
    if (w_srch) begin
      tlb_s1_vppn     = csr_ehi_vppn;
      tlb_s1_va_bit12 = 1'b0;
      tlb_s1_asid     = csr_asid;
      tlb_st_inst     = 1'b0;
    end else if (w_inv) begin
      tlb_s1_vppn     = r_inv_vppn;
      tlb_s1_va_bit12 = 1'b0;
      tlb_s1_asid     = r_inv_asid;
      tlb_st_inst     = 1'b0;
    end
  end

  assign tlb_invtlb_valid = w_inv & ~r_inv_bad & ~rst;
  assign tlb_invtlb_op    = r_inv_op;

  assign tlb_we      = (r_state == S_WR) & ~rst;
  assign tlb_w_index = r_idx;
  assign tlb_w_e     = csr_tlbr_active | ~csr_idx_ne;
  assign tlb_w_vppn  = csr_ehi_vppn;
  assign tlb_w_ps    = csr_idx_ps;
  assign tlb_w_asid  = csr_asid;
  assign tlb_w_g     = csr_elo0[6] & csr_elo1[6];
  assign tlb_w_ppn0  = csr_elo0[27:8];
  assign tlb_w_plv0  = csr_elo0[3:2];
  assign tlb_w_mat0  = csr_elo0[5:4];
  assign tlb_w_d0    = csr_elo0[1];
  assign tlb_w_v0    = csr_elo0[0];
  assign tlb_w_ppn1  = csr_elo1[27:8];
  assign tlb_w_plv1  = csr_elo1[3:2];
  assign tlb_w_mat1  = csr_elo1[5:4];
  assign tlb_w_d1    = csr_elo1[1];
  assign tlb_w_v1    = csr_elo1[0];

  assign tlb_r_index = r_idx;

  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_found = r_resp_found;
  assign resp_index = r_resp_index;
  assign {resp_rd_e, resp_rd_vppn, resp_rd_ps,
          resp_rd_asid, resp_rd_g,
          resp_rd_ppn0, resp_rd_plv0, resp_rd_mat0,
          resp_rd_d0, resp_rd_v0,
          resp_rd_ppn1, resp_rd_plv1, resp_rd_mat1,
          resp_rd_d1, resp_rd_v1} = r_rd;

  assign w_unused = ^{csr_elo0[31:28], csr_elo0[7],
                      csr_elo1[31:28], csr_elo1[7]};

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// tb_tlb_op_ctrl: directed bench for tlb_op_ctrl with a small
// behavioural TLB array hooked to its ports.
module tb_tlb_op_ctrl;

  localparam int IDXW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tb_clr = 1'b1;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [2:0] req_op = '0;
  logic [4:0] req_inv_op = '0;
  logic [9:0] req_inv_asid = '0;
  logic [18:0] req_inv_vppn = '0;
  logic [IDXW-1:0] csr_idx_index = '0;
  logic [5:0] csr_idx_ps = 6'd12;
  logic csr_idx_ne = 1'b0;
  logic [18:0] csr_ehi_vppn = '0;
  logic [9:0] csr_asid = '0;
  logic [31:0] csr_elo0 = '0;
  logic [31:0] csr_elo1 = '0;
  logic csr_tlbr_active = 1'b0;
  logic [18:0] mem_s1_vppn = 19'h7FFFF;
  logic mem_s1_va_bit12 = 1'b1;
  logic [9:0] mem_s1_asid = 10'h3FF;
  logic mem_st = 1'b0;
  logic mem_stall;
  logic [18:0] tlb_s1_vppn;
  logic tlb_s1_va_bit12;
  logic [9:0] tlb_s1_asid;
  logic tlb_st_inst;
  logic tlb_s1_found;
  logic [IDXW-1:0] tlb_s1_index;
  logic tlb_invtlb_valid;
  logic [4:0] tlb_invtlb_op;
  logic tlb_we;
  logic [IDXW-1:0] tlb_w_index;
  logic tlb_w_e, tlb_w_g;
  logic [18:0] tlb_w_vppn;
  logic [5:0] tlb_w_ps;
  logic [9:0] tlb_w_asid;
  logic [19:0] tlb_w_ppn0, tlb_w_ppn1;
  logic [1:0] tlb_w_plv0, tlb_w_mat0, tlb_w_plv1, tlb_w_mat1;
  logic tlb_w_d0, tlb_w_v0, tlb_w_d1, tlb_w_v1;
  logic [IDXW-1:0] tlb_r_index;
  logic tlb_r_e, tlb_r_g;
  logic [18:0] tlb_r_vppn;
  logic [5:0] tlb_r_ps;
  logic [9:0] tlb_r_asid;
  logic [19:0] tlb_r_ppn0, tlb_r_ppn1;
  logic [1:0] tlb_r_plv0, tlb_r_mat0, tlb_r_plv1, tlb_r_mat1;
  logic tlb_r_d0, tlb_r_v0, tlb_r_d1, tlb_r_v1;
  logic resp_valid, resp_err, resp_found;
  logic [IDXW-1:0] resp_index;
  logic resp_rd_e, resp_rd_g;
  logic [18:0] resp_rd_vppn;
  logic [5:0] resp_rd_ps;
  logic [9:0] resp_rd_asid;
  logic [19:0] resp_rd_ppn0, resp_rd_ppn1;
  logic [1:0] resp_rd_plv0, resp_rd_mat0, resp_rd_plv1, resp_rd_mat1;
  logic resp_rd_d0, resp_rd_v0, resp_rd_d1, resp_rd_v1;

  int pass_cnt = 0;
  int total = 0;
  int cyc = 0;
  int we_cnt = 0;
  int inv_cnt = 0;

  tlb_op_ctrl #(.TLBNUM(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_inv_op(req_inv_op), .req_inv_asid(req_inv_asid),
    .req_inv_vppn(req_inv_vppn),
    .csr_idx_index(csr_idx_index), .csr_idx_ps(csr_idx_ps),
    .csr_idx_ne(csr_idx_ne), .csr_ehi_vppn(csr_ehi_vppn),
    .csr_asid(csr_asid), .csr_elo0(csr_elo0), .csr_elo1(csr_elo1),
    .csr_tlbr_active(csr_tlbr_active),
    .mem_s1_vppn(mem_s1_vppn), .mem_s1_va_bit12(mem_s1_va_bit12),
    .mem_s1_asid(mem_s1_asid), .mem_st(mem_st), .mem_stall(mem_stall),
    .tlb_s1_vppn(tlb_s1_vppn), .tlb_s1_va_bit12(tlb_s1_va_bit12),
    .tlb_s1_asid(tlb_s1_asid), .tlb_st_inst(tlb_st_inst),
    .tlb_s1_found(tlb_s1_found), .tlb_s1_index(tlb_s1_index),
    .tlb_invtlb_valid(tlb_invtlb_valid), .tlb_invtlb_op(tlb_invtlb_op),
    .tlb_we(tlb_we), .tlb_w_index(tlb_w_index), .tlb_w_e(tlb_w_e),
    .tlb_w_vppn(tlb_w_vppn), .tlb_w_ps(tlb_w_ps),
    .tlb_w_asid(tlb_w_asid), .tlb_w_g(tlb_w_g),
    .tlb_w_ppn0(tlb_w_ppn0), .tlb_w_plv0(tlb_w_plv0),
    .tlb_w_mat0(tlb_w_mat0), .tlb_w_d0(tlb_w_d0), .tlb_w_v0(tlb_w_v0),
    .tlb_w_ppn1(tlb_w_ppn1), .tlb_w_plv1(tlb_w_plv1),
    .tlb_w_mat1(tlb_w_mat1), .tlb_w_d1(tlb_w_d1), .tlb_w_v1(tlb_w_v1),
    .tlb_r_index(tlb_r_index), .tlb_r_e(tlb_r_e),
    .tlb_r_vppn(tlb_r_vppn), .tlb_r_ps(tlb_r_ps),
    .tlb_r_asid(tlb_r_asid), .tlb_r_g(tlb_r_g),
    .tlb_r_ppn0(tlb_r_ppn0), .tlb_r_plv0(tlb_r_plv0),
    .tlb_r_mat0(tlb_r_mat0), .tlb_r_d0(tlb_r_d0), .tlb_r_v0(tlb_r_v0),
    .tlb_r_ppn1(tlb_r_ppn1), .tlb_r_plv1(tlb_r_plv1),
    .tlb_r_mat1(tlb_r_mat1), .tlb_r_d1(tlb_r_d1), .tlb_r_v1(tlb_r_v1),
    .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_found(resp_found), .resp_index(resp_index),
    .resp_rd_e(resp_rd_e), .resp_rd_vppn(resp_rd_vppn),
    .resp_rd_ps(resp_rd_ps), .resp_rd_asid(resp_rd_asid),
    .resp_rd_g(resp_rd_g),
    .resp_rd_ppn0(resp_rd_ppn0), .resp_rd_plv0(resp_rd_plv0),
    .resp_rd_mat0(resp_rd_mat0), .resp_rd_d0(resp_rd_d0),
    .resp_rd_v0(resp_rd_v0),
    .resp_rd_ppn1(resp_rd_ppn1), .resp_rd_plv1(resp_rd_plv1),
    .resp_rd_mat1(resp_rd_mat1), .resp_rd_d1(resp_rd_d1),
    .resp_rd_v1(resp_rd_v1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic e; logic [18:0] vppn; logic [5:0] ps;
    logic [9:0] asid; logic g;
    logic [19:0] ppn0; logic [1:0] plv0; logic [1:0] mat0;
    logic d0; logic v0;
    logic [19:0] ppn1; logic [1:0] plv1; logic [1:0] mat1;
    logic d1; logic v1;
  } ent_t;

  ent_t tlb_m [16];

  function automatic logic vmatch(ent_t en, logic [18:0] v);
    if (en.ps == 6'd21) return en.vppn[18:9] == v[18:9];
    return en.vppn == v;
  endfunction

  function automatic logic inv_hit(ent_t en, logic [4:0] op,
                                   logic [9:0] a, logic [18:0] v);
    logic am;
    am = (en.asid == a);
    case (op)
      5'd0, 5'd1: return 1'b1;
      5'd2: return en.g;
      5'd3: return !en.g;
      5'd4: return !en.g && am;
      5'd5: return !en.g && am && vmatch(en, v);
      5'd6: return (en.g || am) && vmatch(en, v);
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    tlb_s1_found = 1'b0;
    tlb_s1_index = '0;
    for (int i = 0; i < 16; i++) begin
      if (tlb_m[i].e && vmatch(tlb_m[i], tlb_s1_vppn) &&
          (tlb_m[i].g || tlb_m[i].asid == tlb_s1_asid)) begin
        tlb_s1_found = 1'b1;
        tlb_s1_index = 4'(i);
      end
    end
  end

  assign {tlb_r_e, tlb_r_vppn, tlb_r_ps, tlb_r_asid, tlb_r_g,
          tlb_r_ppn0, tlb_r_plv0, tlb_r_mat0, tlb_r_d0, tlb_r_v0,
          tlb_r_ppn1, tlb_r_plv1, tlb_r_mat1, tlb_r_d1, tlb_r_v1}
         = tlb_m[tlb_r_index];

  always @(posedge clk) begin
    if (tb_clr) begin
      for (int i = 0; i < 16; i++) tlb_m[i] <= '0;
    end else begin
      if (tlb_invtlb_valid)
        for (int i = 0; i < 16; i++)
          if (inv_hit(tlb_m[i], tlb_invtlb_op, tlb_s1_asid, tlb_s1_vppn))
            tlb_m[i].e <= 1'b0;
      if (tlb_we)
        tlb_m[tlb_w_index] <= '{e: tlb_w_e, vppn: tlb_w_vppn,
          ps: tlb_w_ps, asid: tlb_w_asid, g: tlb_w_g,
          ppn0: tlb_w_ppn0, plv0: tlb_w_plv0, mat0: tlb_w_mat0,
          d0: tlb_w_d0, v0: tlb_w_v0,
          ppn1: tlb_w_ppn1, plv1: tlb_w_plv1, mat1: tlb_w_mat1,
          d1: tlb_w_d1, v1: tlb_w_v1};
    end
  end

  always @(posedge clk) begin
    cyc <= rst ? 0 : cyc + 1;
    if (tlb_we) we_cnt <= we_cnt + 1;
    if (tlb_invtlb_valid) inv_cnt <= inv_cnt + 1;
  end

  // Returns #1 after the accept edge; acc is the cycle count at accept.
  task automatic issue(input logic [2:0] op, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1;
    req_op = op;
    acc = cyc;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Cycles from accept to resp_valid; gives up at 8.
  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tb_clr = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tb_clr = 1'b0;
    total++; if (req_ready !== 1'b1) $display("FAIL rst_ready got %b exp 1", req_ready); else pass_cnt++;
    total++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid got %b exp 0", resp_valid); else pass_cnt++;
    total++; if (resp_err !== 1'b0) $display("FAIL rst_resp_err got %b exp 0", resp_err); else pass_cnt++;
    total++; if (resp_found !== 1'b0) $display("FAIL rst_resp_found got %b exp 0", resp_found); else pass_cnt++;
    total++; if (resp_index !== 4'd0) $display("FAIL rst_resp_index got %h exp 0", resp_index); else pass_cnt++;
    total++; if (resp_rd_vppn !== 19'd0) $display("FAIL rst_rd_vppn got %h exp 0", resp_rd_vppn); else pass_cnt++;
    total++; if (tlb_we !== 1'b0) $display("FAIL rst_we got %b exp 0", tlb_we); else pass_cnt++;
    total++; if (tlb_invtlb_valid !== 1'b0) $display("FAIL rst_inv got %b exp 0", tlb_invtlb_valid); else pass_cnt++;
    total++; if (mem_stall !== 1'b0) $display("FAIL rst_stall got %b exp 0", mem_stall); else pass_cnt++;
  endtask

  task automatic test_wr_srch;
    int acc, lat, w0;
    csr_idx_index = 4'd3; csr_idx_ps = 6'd12; csr_idx_ne = 1'b0;
    csr_ehi_vppn = 19'h12345; csr_asid = 10'h5;
    csr_elo0 = 32'h0ABCDE1F; csr_elo1 = 32'h01234501;
    csr_tlbr_active = 1'b0;
    w0 = we_cnt;
    issue(3'd2, acc);
    total++; if (tlb_we !== 1'b1) $display("FAIL wr_we got %b exp 1", tlb_we); else pass_cnt++;
    total++; if (tlb_w_index !== 4'd3) $display("FAIL wr_index got %h exp 3", tlb_w_index); else pass_cnt++;
    total++; if (tlb_w_e !== 1'b1) $display("FAIL wr_e got %b exp 1", tlb_w_e); else pass_cnt++;
    total++; if (tlb_w_vppn !== 19'h12345) $display("FAIL wr_vppn got %h exp 12345", tlb_w_vppn); else pass_cnt++;
    total++; if (tlb_w_g !== 1'b0) $display("FAIL wr_g got %b exp 0", tlb_w_g); else pass_cnt++;
    total++; if (tlb_w_ppn0 !== 20'hABCDE) $display("FAIL wr_ppn0 got %h exp abcde", tlb_w_ppn0); else pass_cnt++;
    total++; if ({tlb_w_plv0, tlb_w_mat0} !== 4'b1101) $display("FAIL wr_plv_mat got %b exp 1101", {tlb_w_plv0, tlb_w_mat0}); else pass_cnt++;
    total++; if (tlb_w_ppn1 !== 20'h12345) $display("FAIL wr_ppn1 got %h exp 12345", tlb_w_ppn1); else pass_cnt++;
    wait_resp(lat);
    total++; if (lat !== 2) $display("FAIL wr_latency got %0d exp 2", lat); else pass_cnt++;
    total++; if (we_cnt - w0 !== 1) $display("FAIL wr_we_cycles got %0d exp 1", we_cnt - w0); else pass_cnt++;
    csr_idx_index = 4'd0;
    issue(3'd0, acc);
    total++; if (mem_stall !== 1'b1) $display("FAIL srch_stall got %b exp 1", mem_stall); else pass_cnt++;
    total++; if (tlb_s1_vppn !== 19'h12345) $display("FAIL srch_port_vppn got %h exp 12345", tlb_s1_vppn); else pass_cnt++;
    total++; if (tlb_s1_va_bit12 !== 1'b0) $display("FAIL srch_bit12 got %b exp 0", tlb_s1_va_bit12); else pass_cnt++;
    wait_resp(lat);
    total++; if (lat !== 2) $display("FAIL srch_latency got %0d exp 2", lat); else pass_cnt++;
    total++; if (resp_found !== 1'b1) $display("FAIL srch_found got %b exp 1", resp_found); else pass_cnt++;
    total++; if (resp_index !== 4'd3) $display("FAIL srch_index got %h exp 3", resp_index); else pass_cnt++;
  endtask

  task automatic test_rd;
    int acc, lat;
    csr_idx_index = 4'd3;
    issue(3'd1, acc);
    total++; if (tlb_r_index !== 4'd3) $display("FAIL rd_r_index got %h exp 3", tlb_r_index); else pass_cnt++;
    wait_resp(lat);
    total++; if (lat !== 2) $display("FAIL rd_latency got %0d exp 2", lat); else pass_cnt++;
    total++; if (resp_rd_vppn !== 19'h12345) $display("FAIL rd_vppn got %h exp 12345", resp_rd_vppn); else pass_cnt++;
    total++; if (resp_rd_e !== 1'b1) $display("FAIL rd_e got %b exp 1", resp_rd_e); else pass_cnt++;
    total++; if (resp_rd_ps !== 6'd12) $display("FAIL rd_ps got %0d exp 12", resp_rd_ps); else pass_cnt++;
    total++; if (resp_rd_ppn0 !== 20'hABCDE) $display("FAIL rd_ppn0 got %h exp abcde", resp_rd_ppn0); else pass_cnt++;
    total++; if (resp_rd_asid !== 10'h5) $display("FAIL rd_asid got %h exp 5", resp_rd_asid); else pass_cnt++;
    csr_idx_index = 4'd4; csr_idx_ne = 1'b1; csr_ehi_vppn = 19'h00F0F;
    issue(3'd2, acc);
    total++; if (tlb_w_e !== 1'b0) $display("FAIL wr_ne_e got %b exp 0", tlb_w_e); else pass_cnt++;
    wait_resp(lat);
    issue(3'd1, acc);
    wait_resp(lat);
    total++; if (resp_rd_e !== 1'b0) $display("FAIL rd_ne_e got %b exp 0", resp_rd_e); else pass_cnt++;
    total++; if (resp_rd_vppn !== 19'h00F0F) $display("FAIL rd_ne_vppn got %h exp 00f0f", resp_rd_vppn); else pass_cnt++;
    csr_idx_ne = 1'b0;
  endtask

  task automatic test_inv;
    int acc, lat, i0;
    req_inv_op = 5'd5; req_inv_asid = 10'h5; req_inv_vppn = 19'h12345;
    i0 = inv_cnt;
    issue(3'd4, acc);
    total++; if (mem_stall !== 1'b1) $display("FAIL inv_stall got %b exp 1", mem_stall); else pass_cnt++;
    total++; if (tlb_s1_asid !== 10'h5) $display("FAIL inv_asid got %h exp 5", tlb_s1_asid); else pass_cnt++;
    total++; if (tlb_invtlb_valid !== 1'b1) $display("FAIL inv_valid got %b exp 1", tlb_invtlb_valid); else pass_cnt++;
    total++; if (tlb_invtlb_op !== 5'd5) $display("FAIL inv_op got %0d exp 5", tlb_invtlb_op); else pass_cnt++;
    wait_resp(lat);
    total++; if (lat !== 2) $display("FAIL inv_latency got %0d exp 2", lat); else pass_cnt++;
    total++; if (resp_err !== 1'b0) $display("FAIL inv_err got %b exp 0", resp_err); else pass_cnt++;
    total++; if (inv_cnt - i0 !== 1) $display("FAIL inv_cycles got %0d exp 1", inv_cnt - i0); else pass_cnt++;
    csr_ehi_vppn = 19'h12345; csr_asid = 10'h5;
    issue(3'd0, acc);
    wait_resp(lat);
    total++; if (resp_found !== 1'b0) $display("FAIL inv_srch_found got %b exp 0", resp_found); else pass_cnt++;
  endtask

  task automatic test_fill;
    int acc, lat, k0;
    csr_tlbr_active = 1'b1; csr_idx_ne = 1'b1; csr_idx_index = 4'd9;
    csr_ehi_vppn = 19'h55555; csr_asid = 10'h21;
    for (int n = 0; n < 3; n++) begin
      issue(3'd3, acc);
      if (n == 0) k0 = acc % 16;
      total++; if (tlb_we !== 1'b1) $display("FAIL fill_we got %b exp 1", tlb_we); else pass_cnt++;
      total++; if (tlb_w_index !== 4'(acc % 16)) $display("FAIL fill_index got %h exp %h", tlb_w_index, acc % 16); else pass_cnt++;
      total++; if (tlb_w_e !== 1'b1) $display("FAIL fill_e got %b exp 1", tlb_w_e); else pass_cnt++;
      wait_resp(lat);
      total++; if (lat !== 2) $display("FAIL fill_latency got %0d exp 2", lat); else pass_cnt++;
    end
    csr_tlbr_active = 1'b0; csr_idx_ne = 1'b0;
    csr_idx_index = 4'(k0);
    issue(3'd1, acc);
    wait_resp(lat);
    total++; if (resp_rd_vppn !== 19'h55555) $display("FAIL fill_rd_vppn got %h exp 55555", resp_rd_vppn); else pass_cnt++;
    total++; if (resp_rd_e !== 1'b1) $display("FAIL fill_rd_e got %b exp 1", resp_rd_e); else pass_cnt++;
  endtask

  task automatic test_illegal;
    int acc, lat, w0, i0;
    w0 = we_cnt; i0 = inv_cnt;
    req_inv_op = 5'd7;
    issue(3'd4, acc);
    total++; if (tlb_invtlb_valid !== 1'b0) $display("FAIL inv7_valid got %b exp 0", tlb_invtlb_valid); else pass_cnt++;
    wait_resp(lat);
    total++; if (lat !== 2) $display("FAIL inv7_latency got %0d exp 2", lat); else pass_cnt++;
    total++; if (resp_err !== 1'b1) $display("FAIL inv7_err got %b exp 1", resp_err); else pass_cnt++;
    issue(3'd6, acc);
    wait_resp(lat);
    total++; if (lat !== 1) $display("FAIL op6_latency got %0d exp 1", lat); else pass_cnt++;
    total++; if (resp_err !== 1'b1) $display("FAIL op6_err got %b exp 1", resp_err); else pass_cnt++;
    total++; if (we_cnt != w0 || inv_cnt != i0) $display("FAIL illegal_strobe got we %0d inv %0d exp 0 0", we_cnt - w0, inv_cnt - i0); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int acc, lat;
    csr_idx_index = 4'd7; csr_ehi_vppn = 19'h11111; csr_asid = 10'h9;
    issue(3'd2, acc);
    wait_resp(lat);
    csr_ehi_vppn = 19'h22222;
    issue(3'd2, acc);
    rst = 1'b1;
    #1;
    total++; if (tlb_we !== 1'b0) $display("FAIL rstmid_we got %b exp 0", tlb_we); else pass_cnt++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    total++; if (req_ready !== 1'b1) $display("FAIL rstmid_ready got %b exp 1", req_ready); else pass_cnt++;
    total++; if (resp_valid !== 1'b0) $display("FAIL rstmid_resp got %b exp 0", resp_valid); else pass_cnt++;
    @(posedge clk);
    #1;
    total++; if (resp_valid !== 1'b0) $display("FAIL rstmid_resp2 got %b exp 0", resp_valid); else pass_cnt++;
    issue(3'd1, acc);
    wait_resp(lat);
    total++; if (resp_rd_vppn !== 19'h11111) $display("FAIL rstmid_rd_vppn got %h exp 11111", resp_rd_vppn); else pass_cnt++;
  endtask

  task automatic test_st_inst;
    int acc, lat;
    mem_st = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++; if (tlb_st_inst !== 1'b1) $display("FAIL idle_st got %b exp 1", tlb_st_inst); else pass_cnt++;
    total++; if (tlb_s1_vppn !== 19'h7FFFF) $display("FAIL idle_vppn got %h exp 7ffff", tlb_s1_vppn); else pass_cnt++;
    total++; if (tlb_s1_asid !== 10'h3FF) $display("FAIL idle_asid got %h exp 3ff", tlb_s1_asid); else pass_cnt++;
    issue(3'd0, acc);
    total++; if (tlb_st_inst !== 1'b0) $display("FAIL srch_st got %b exp 0", tlb_st_inst); else pass_cnt++;
    wait_resp(lat);
    mem_st = 1'b0;
  endtask

  task automatic test_back_to_back;
    int a, b, lat;
    csr_idx_index = 4'd7;
    issue(3'd1, a);
    wait_resp(lat);
    issue(3'd1, b);
    total++; if (b - a !== 3) $display("FAIL b2b_spacing got %0d exp 3", b - a); else pass_cnt++;
    wait_resp(lat);
    total++; if (lat !== 2) $display("FAIL b2b_latency got %0d exp 2", lat); else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_wr_srch;
    test_rd;
    test_inv;
    test_fill;
    test_illegal;
    test_reset_mid;
    test_st_inst;
    test_back_to_back;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
